// File: rtl/pwm_pkg.sv
// Shared types and limits for the PWM capture path.
package pwm_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_HIGH = 2'd1,
        CAP_LOW  = 2'd2
    } pwm_cap_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/pwm_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by one
// history flop that turns level changes into single-cycle rise/fall strobes.
module pwm_edge_sync
    import pwm_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Out-of-range stage counts are clamped into the supported window.
    localparam int STAGES = (SyncStages < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SyncStages > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SyncStages;

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain and edge-history flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d_i};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign level_o = sync_r[STAGES-1];
    assign rise_o  = sync_r[STAGES-1] & ~prev_r;
    assign fall_o  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM waveform in clock
// cycles and hands each complete measurement out over valid/ready.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int Resolution = 16,
    parameter int SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic                  pwm_i,
    output logic                  meas_valid_o,
    input  logic                  meas_ready_i,
    output logic [Resolution-1:0] high_count_o,
    output logic [Resolution-1:0] period_count_o,
    output logic                  timeout_o,
    output logic                  missed_o
);

    localparam logic [Resolution-1:0] CNT_ZERO = {Resolution{1'b0}};
    localparam logic [Resolution-1:0] CNT_ONE  = {{(Resolution-1){1'b0}}, 1'b1};
    localparam logic [Resolution-1:0] CNT_MAX  = {Resolution{1'b1}};

    pwm_cap_state_e        state_r;
    logic [Resolution-1:0] cnt_r;
    logic [Resolution-1:0] hi_r;
    logic                  valid_r;
    logic [Resolution-1:0] high_r;
    logic [Resolution-1:0] period_r;
    logic                  timeout_r;
    logic                  missed_r;

    logic level_s;
    logic rise_s;
    logic fall_s;
    logic sat_s;
    logic publish_s;
    logic load_s;
    logic drop_s;

    pwm_edge_sync #(
        .SyncStages (SyncStages)
    ) u_edge_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (pwm_i),
        .level_o (level_s),
        .rise_o  (rise_s),
        .fall_o  (fall_s)
    );

    // Saturation outranks a coincident edge; a publish only lands when the output slot is free or being drained.
    always_comb begin
        sat_s     = 1'b0;
        publish_s = 1'b0;
        if (enable_i && (state_r != CAP_IDLE) && (cnt_r == CNT_MAX)) begin
            sat_s = 1'b1;
        end else begin
            sat_s = 1'b0;
        end
        if (enable_i && !sat_s && (state_r == CAP_LOW) && rise_s) begin
            publish_s = 1'b1;
        end else begin
            publish_s = 1'b0;
        end
        load_s = publish_s && (!valid_r || meas_ready_i);
        drop_s = publish_s && valid_r && !meas_ready_i;
    end

    // Capture state machine and cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= CAP_IDLE;
            cnt_r   <= CNT_ZERO;
            hi_r    <= CNT_ZERO;
        end else if (!enable_i || sat_s) begin
            state_r <= CAP_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                CAP_IDLE: begin
                    if (rise_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= CAP_HIGH;
                    end
                end
                CAP_HIGH: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (fall_s) begin
                        hi_r    <= cnt_r;
                        state_r <= CAP_LOW;
                    end
                end
                CAP_LOW: begin
                    if (rise_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= CAP_HIGH;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= CAP_IDLE;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r  <= 1'b0;
            high_r   <= CNT_ZERO;
            period_r <= CNT_ZERO;
        end else if (!enable_i) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r  <= 1'b1;
            high_r   <= hi_r;
            period_r <= cnt_r;
        end else if (valid_r && meas_ready_i) begin
            valid_r <= 1'b0;
        end
    end

    // Sticky status flags; a new event beats a coincident clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_r <= 1'b0;
            missed_r  <= 1'b0;
        end else begin
            if (sat_s) begin
                timeout_r <= 1'b1;
            end else if (clear_i) begin
                timeout_r <= 1'b0;
            end
            if (drop_s) begin
                missed_r <= 1'b1;
            end else if (clear_i) begin
                missed_r <= 1'b0;
            end
        end
    end

    assign meas_valid_o   = valid_r;
    assign high_count_o   = high_r;
    assign period_count_o = period_r;
    assign timeout_o      = timeout_r;
    assign missed_o       = missed_r;

endmodule
